alu_mem_master: RTL



---
 rtl/alu_mem_pkg.sv | 40 ++++
 rtl/alu_mem_wait_cnt.sv | 30 +++
 rtl/alu_mem_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mem_pkg.sv
// Shared constants and types for the memory-mapped ALU initiator.
// Register map, opcodes, FSM state encoding and the divide-by-zero marker.
package alu_mem_pkg;

  localparam logic [1:0] ADDR_A    = 2'd0;
  localparam logic [1:0] ADDR_B    = 2'd1;
  localparam logic [1:0] ADDR_OPER = 2'd2;
  localparam logic [1:0] ADDR_EXEC = 2'd3;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_MUL  = 3'd3,
    OP_DIV  = 3'd4
  } alu_op_e;

  localparam logic [15:0] DIV0_RESULT = 16'hDEAD;

  localparam int CNT_W = 4;

  typedef logic [3:0] state_t;
  localparam state_t ST_INIT    = 4'd0;
  localparam state_t ST_IDLE    = 4'd1;
  localparam state_t ST_WR_A    = 4'd2;
  localparam state_t ST_WR_B    = 4'd3;
  localparam state_t ST_WR_OP   = 4'd4;
  localparam state_t ST_RD_OP   = 4'd5;
  localparam state_t ST_RD_WAIT = 4'd6;
  localparam state_t ST_WR_EXE  = 4'd7;
  localparam state_t ST_EX_WAIT = 4'd8;
  localparam state_t ST_CAPTURE = 4'd9;
  localparam state_t ST_CLR_EXE = 4'd10;
  localparam state_t ST_RESP    = 4'd11;

  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mem_wait_cnt.sv
// Loadable down-counter used for the read-back and result wait windows.
// Counts down to zero and holds there until loaded again.
module alu_mem_wait_cnt
  import alu_mem_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load has priority over the decrement; saturate at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/alu_mem_master.sv
// Initiator that turns one ALU command into register writes on the mem bus and
// returns the captured ALU result on a valid/ready response port.
module alu_mem_master
  import alu_mem_pkg::*;
#(
  parameter int          ADDR_WIDTH = 2,
  parameter int          DATA_WIDTH = 8,
  parameter int          RES_WAIT   = 2,
  parameter int unsigned READBACK   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_result,
  output logic                  rsp_err,
  output logic                  rsp_dz,
  output logic                  mem_enable,
  output logic                  mem_rd_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic [15:0]           mem_res_out
);

  state_t                state_q, state_d;
  logic                  init_done_q, init_done_d;
  logic [2:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  req_ready_q, req_ready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [15:0]           rsp_result_q, rsp_result_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_dz_q, rsp_dz_d;

  logic                  cnt_load_s;
  logic [CNT_W-1:0]      cnt_val_s;
  logic                  cnt_zero_s;
  logic [DATA_WIDTH-1:0] rd_oper_s;
  logic                  div0_s;

  alu_mem_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .zero_o     (cnt_zero_s)
  );

  assign rd_oper_s = mem_rd_data & DATA_WIDTH'(3'b111);
  assign div0_s    = (op_q == OP_DIV) && (b_q == {DATA_WIDTH{1'b0}});

  // Bus outputs are decided one cycle ahead so every port comes from a flop.
  always_comb begin
    state_d       = state_q;
    init_done_d   = init_done_q;
    op_d          = op_q;
    b_d           = b_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = 1'b1;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    req_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_err_d     = rsp_err_q;
    rsp_dz_d      = rsp_dz_q;
    cnt_load_s    = 1'b0;
    cnt_val_s     = {CNT_W{1'b0}};

    case (state_q)
      ST_INIT: begin
        // The responder powers up executing; stop it before the first command.
        if (!init_done_q) begin
          init_done_d   = 1'b1;
          mem_enable_d  = 1'b1;
          mem_rd_wr_d   = 1'b0;
          mem_addr_d    = ADDR_WIDTH'(ADDR_EXEC);
          mem_wr_data_d = {DATA_WIDTH{1'b0}};
        end else begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d         = req_op;
          b_d          = req_b;
          rsp_result_d = 16'h0000;
          rsp_err_d    = 1'b0;
          rsp_dz_d     = 1'b0;
          if (!op_is_valid(req_op)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d       = ST_WR_A;
            mem_enable_d  = 1'b1;
            mem_rd_wr_d   = 1'b0;
            mem_addr_d    = ADDR_WIDTH'(ADDR_A);
            mem_wr_data_d = req_a;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      ST_WR_A: begin
        state_d       = ST_WR_B;
        mem_enable_d  = 1'b1;
        mem_rd_wr_d   = 1'b0;
        mem_addr_d    = ADDR_WIDTH'(ADDR_B);
        mem_wr_data_d = b_q;
      end
      ST_WR_B: begin
        state_d       = ST_WR_OP;
        mem_enable_d  = 1'b1;
        mem_rd_wr_d   = 1'b0;
        mem_addr_d    = ADDR_WIDTH'(ADDR_OPER);
        mem_wr_data_d = DATA_WIDTH'(op_q);
      end
      ST_WR_OP: begin
        if (READBACK != 0) begin
          state_d      = ST_RD_OP;
          mem_enable_d = 1'b1;
          mem_rd_wr_d  = 1'b1;
          mem_addr_d   = ADDR_WIDTH'(ADDR_OPER);
        end else begin
          state_d       = ST_WR_EXE;
          mem_enable_d  = 1'b1;
          mem_rd_wr_d   = 1'b0;
          mem_addr_d    = ADDR_WIDTH'(ADDR_EXEC);
          mem_wr_data_d = DATA_WIDTH'(1'b1);
        end
      end
      ST_RD_OP: begin
        // Read data lands two cycles after the read cycle: wait two RD_WAIT cycles.
        state_d    = ST_RD_WAIT;
        cnt_load_s = 1'b1;
        cnt_val_s  = CNT_W'(1);
      end
      ST_RD_WAIT: begin
        if (cnt_zero_s) begin
          if (rd_oper_s != DATA_WIDTH'(op_q)) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d       = ST_WR_EXE;
            mem_enable_d  = 1'b1;
            mem_rd_wr_d   = 1'b0;
            mem_addr_d    = ADDR_WIDTH'(ADDR_EXEC);
            mem_wr_data_d = DATA_WIDTH'(1'b1);
          end
        end else begin
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_EXE: begin
        state_d    = ST_EX_WAIT;
        cnt_load_s = 1'b1;
        cnt_val_s  = CNT_W'(RES_WAIT - 2);
      end
      ST_EX_WAIT: begin
        if (cnt_zero_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = ST_EX_WAIT;
        end
      end
      ST_CAPTURE: begin
        // The response is presented while EXECUTE is being cleared.
        state_d       = ST_CLR_EXE;
        rsp_valid_d   = 1'b1;
        rsp_dz_d      = div0_s;
        rsp_result_d  = div0_s ? DIV0_RESULT : mem_res_out;
        mem_enable_d  = 1'b1;
        mem_rd_wr_d   = 1'b0;
        mem_addr_d    = ADDR_WIDTH'(ADDR_EXEC);
        mem_wr_data_d = {DATA_WIDTH{1'b0}};
      end
      ST_CLR_EXE: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_INIT;
        init_done_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_INIT;
      init_done_q   <= 1'b0;
      op_q          <= 3'd0;
      b_q           <= {DATA_WIDTH{1'b0}};
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b1;
      mem_addr_q    <= {ADDR_WIDTH{1'b0}};
      mem_wr_data_q <= {DATA_WIDTH{1'b0}};
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 16'h0000;
      rsp_err_q     <= 1'b0;
      rsp_dz_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_done_q   <= init_done_d;
      op_q          <= op_d;
      b_q           <= b_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_err_q     <= rsp_err_d;
      rsp_dz_q      <= rsp_dz_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_dz      = rsp_dz_q;
  assign mem_enable  = mem_enable_q;
  assign mem_rd_wr   = mem_rd_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wr_data = mem_wr_data_q;

endmodule
